// File: rtl/seg_pkg.sv
// Shared seven-segment constants: active-low glyphs ordered {G,F,E,D,C,B,A}.
package seg_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [6:0] GLYPH_0 = 7'b1000000;
    localparam logic [6:0] GLYPH_1 = 7'b1111001;
    localparam logic [6:0] GLYPH_2 = 7'b0100100;
    localparam logic [6:0] GLYPH_3 = 7'b0110000;
    localparam logic [6:0] GLYPH_4 = 7'b0011001;
    localparam logic [6:0] GLYPH_5 = 7'b0010010;
    localparam logic [6:0] GLYPH_6 = 7'b0000010;
    localparam logic [6:0] GLYPH_7 = 7'b1111000;
    localparam logic [6:0] GLYPH_8 = 7'b0000000;
    localparam logic [6:0] GLYPH_9 = 7'b0010000;
    localparam logic [6:0] GLYPH_A = 7'b0001000;
    localparam logic [6:0] GLYPH_B = 7'b0000011;
    localparam logic [6:0] GLYPH_C = 7'b1000110;
    localparam logic [6:0] GLYPH_D = 7'b0100001;
    localparam logic [6:0] GLYPH_E = 7'b0000110;
    localparam logic [6:0] GLYPH_F = 7'b0001110;

endpackage

// File: rtl/hex_glyph.sv
// Combinational hex nibble to active-low seven-segment glyph decoder.
module hex_glyph
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (nibble)
            4'h0: seg = GLYPH_0;
            4'h1: seg = GLYPH_1;
            4'h2: seg = GLYPH_2;
            4'h3: seg = GLYPH_3;
            4'h4: seg = GLYPH_4;
            4'h5: seg = GLYPH_5;
            4'h6: seg = GLYPH_6;
            4'h7: seg = GLYPH_7;
            4'h8: seg = GLYPH_8;
            4'h9: seg = GLYPH_9;
            4'hA: seg = GLYPH_A;
            4'hB: seg = GLYPH_B;
            4'hC: seg = GLYPH_C;
            4'hD: seg = GLYPH_D;
            4'hE: seg = GLYPH_E;
            4'hF: seg = GLYPH_F;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/hex_display_scan.sv
// Multiplexed hex display scanner with shadowed frame, anti-ghost guard band
// and optional leading-zero blanking; all outputs registered.
module hex_display_scan
    import seg_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int GUARD       = 16,
    parameter int BLANK_LZ    = 1
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    input  logic [4*DIGITS-1:0]   VALUE,
    input  logic [DIGITS-1:0]     DP,
    input  logic                  EN,
    output logic [6:0]            S,
    output logic                  DP_N,
    output logic [DIGITS-1:0]     AN,
    output logic                  FRAME
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [CNT_W-1:0]      cnt;
    logic [IDX_W-1:0]      idx;
    logic [4*DIGITS-1:0]   shadow_value;
    logic [DIGITS-1:0]     shadow_dp;

    logic [DIGITS:0]       zero_from;
    logic [3:0]            nibble_sel;
    logic                  dp_sel;
    logic                  blank_sel;
    logic [DIGITS-1:0]     an_sel;
    logic                  slot_active;
    logic                  frame_start;
    logic [6:0]            glyph;

    // zero_from[i] is set when nibbles i..DIGITS-1 of the shadow are all zero
    always_comb begin
        zero_from = '0;
        zero_from[DIGITS] = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_from[i] = zero_from[i+1] && (shadow_value[i*4 +: 4] == 4'h0);
        end
    end

    always_comb begin
        nibble_sel = 4'h0;
        dp_sel     = 1'b0;
        blank_sel  = 1'b0;
        an_sel     = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                nibble_sel = shadow_value[i*4 +: 4];
                dp_sel     = shadow_dp[i];
                blank_sel  = (BLANK_LZ != 0) && (i > 0) && zero_from[i];
                an_sel[i]  = 1'b0;
            end
        end
    end

    assign slot_active = (int'(cnt) >= GUARD);
    assign frame_start = (cnt == '0) && (idx == '0);

    hex_glyph u_glyph (
        .nibble (nibble_sel),
        .seg    (glyph)
    );

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            cnt          <= '0;
            idx          <= '0;
            shadow_value <= '0;
            shadow_dp    <= '0;
            S            <= SEG_BLANK;
            DP_N         <= 1'b1;
            AN           <= '1;
            FRAME        <= 1'b0;
        end else if (!EN) begin
            cnt   <= '0;
            idx   <= '0;
            S     <= SEG_BLANK;
            DP_N  <= 1'b1;
            AN    <= '1;
            FRAME <= 1'b0;
        end else begin
            if (frame_start) begin
                shadow_value <= VALUE;
                shadow_dp    <= DP;
            end
            FRAME <= frame_start;

            if (cnt == CNT_W'(REFRESH_DIV - 1)) begin
                cnt <= '0;
                idx <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end

            // Guard cycles keep every anode dark so the previous digit cannot ghost
            AN   <= slot_active ? an_sel : '1;
            S    <= (slot_active && !blank_sel) ? glyph : SEG_BLANK;
            DP_N <= slot_active ? ~dp_sel : 1'b1;
        end
    end

endmodule

// File: doc/hex_display_scan.md
HEX_DISPLAY_SCAN -- requirements
Module: hex_display_scan

Interface
REQ-001 SHALL have parameter DIGITS, default 4, number of multiplexed hex digits (legal 1..8).
REQ-002 SHALL have parameter REFRESH_DIV, default 50000, clock cycles per digit slot (legal >= 2).
REQ-003 SHALL have parameter GUARD, default 16, blanked cycles at the start of each slot for anti-ghosting (legal 0..REFRESH_DIV-1).
REQ-004 SHALL have parameter BLANK_LZ, default 1, enabling leading-zero blanking when 1.
REQ-005 SHALL have port CLK, input, 1, the single clock; all flops rising-edge.
REQ-006 SHALL have port RESET_N, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port VALUE, input, 4*DIGITS, hex value; nibble i drives digit i, where digit 0 is rightmost.
REQ-008 SHALL have port DP, input, DIGITS, per-digit decimal point request, 1 = lit.
REQ-009 SHALL have port EN, input, 1, display enable.
REQ-010 SHALL have port S, output, 7, active-low segments with S[0]=A through S[6]=G.
REQ-011 SHALL have port DP_N, output, 1, active-low decimal point.
REQ-012 SHALL have port AN, output, DIGITS, active-low digit anode select, at most one low at any time.
REQ-013 SHALL have port FRAME, output, 1, one-cycle pulse marking each shadow load.

Function
REQ-014 SHALL keep the slot counter cnt in 0..REFRESH_DIV-1 and the digit index idx in 0..DIGITS-1; cnt increments every cycle while EN=1; at cnt=REFRESH_DIV-1, cnt wraps to 0 and idx advances, with DIGITS-1 wrapping to 0.
REQ-015 SHALL load VALUE and DP into shadow registers, and pulse FRAME, on every cycle with EN=1, cnt=0 and idx=0; the display SHALL use only shadow contents, so there is no tearing mid-frame.
REQ-016 SHALL register all outputs; outputs in cycle n+1 reflect cnt, idx and shadow in cycle n, giving one-cycle latency.
REQ-017 SHALL drive AN[idx] low only when EN=1 and cnt >= GUARD; otherwise all AN are high.
REQ-018 SHALL decode the shadow nibble idx with the standard hex glyph set: 0=7'b1000000, 1=7'b1111001, 8=7'b0000000, F=7'b0001110; b and d are lowercase.
REQ-019 SHALL, when BLANK_LZ=1, blank digit i>0 (S=7'h7F, AN still scanned) if shadow nibbles i..DIGITS-1 are all zero; digit 0 is never blanked, so value 0 shows "0".
REQ-020 SHALL drive DP_N = ~shadow DP[idx] during active slot time, independent of blanking, and 1 otherwise.
REQ-021 SHALL, on EN=0, force cnt=0 and idx=0 the next cycle, drive AN all 1, S=7'h7F, DP_N=1 and FRAME=0, and hold the shadow registers.
REQ-022 SHALL, on EN rising, load the shadow on the first enabled cycle (cnt=0, idx=0), then scan normally.
REQ-023 SHALL treat DIGITS=1 as idx fixed at 0, with a shadow load every REFRESH_DIV cycles.

Reset
REQ-024 SHALL, while RESET_N=0, asynchronously force cnt=0, idx=0, shadow=0, AN all 1, S=7'h7F, DP_N=1 and FRAME=0.
REQ-025 SHALL, on reset assertion mid-slot, abort scanning immediately; after release with EN=1, the first cycle performs a shadow load.

Structure
REQ-026 SHALL place the SEG_BLANK (7'h7F) constant and the 16 glyph constants in shared package seg_pkg.
REQ-027 SHALL implement decode in one combinational sub-module, hex_glyph (4-bit in, 7-bit active-low out), instantiated once on the selected nibble.

Verification (DIGITS=4, REFRESH_DIV=4, GUARD=1, BLANK_LZ=1)
REQ-028 SHALL cover: VALUE=16'h12AF, EN=1 after reset -> FRAME at cycle 1; AN sequence 1110,1101,1011,0111 with glyphs F,A,2,1; AN all-high one cycle at each slot start.
REQ-029 SHALL cover: VALUE=16'h0030 -> digits 3,2 blanked (S=7'h7F), digit 1 shows 3, digit 0 shows 0 (7'b1000000).
REQ-030 SHALL cover: VALUE changed from 16'h1111 to 16'h2222 mid-frame -> remaining slots still show 1; 2 appears only after the next FRAME pulse.
REQ-031 SHALL cover: EN dropped in slot 2 -> next-cycle outputs all inactive; EN re-raised -> FRAME pulse on the first enabled cycle, scan restarts at digit 0.
REQ-032 SHALL cover: RESET_N pulsed low mid-slot -> outputs go inactive without a clock edge; scan restarts at idx=0 with a shadow load.
REQ-033 SHALL cover: DP=4'b0100 with VALUE=0 -> DP_N low only in digit-2 active cycles, although digit 2 is blanked.
